// File: rtl/scmp_bus_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scmp_bus_ctl                                               |
// | Description : SC/MP external bus-cycle controller. Arbitrates through    |
// |               the BREQ/ENIN/ENOUT chain and sequences NADS/NRDS/NWDS     |
// |               with NHOLD wait extension. Optional NHOLD watchdog is      |
// |               enabled by defining SCMP_BUS_TIMEOUT_EN.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module scmp_bus_ctl #(
    parameter int ADS_CYC  = 2,
    parameter int STRB_CYC = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_flags,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        bus_err,
    output logic        breq_o,
    input  logic        enin,
    output logic        enout,
    input  logic        nhold_n,
    output logic        ads_n,
    output logic        rds_n,
    output logic        wds_n,
    output logic [15:0] addr_o,
    output logic [3:0]  flags_o,
    output logic        addr_oe,
    output logic [7:0]  dout,
    output logic        dout_oe,
    input  logic [7:0]  din
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_ADDR = 3'd2;
    localparam logic [2:0] c_ST_STRB = 3'd3;
    localparam logic [2:0] c_ST_REL  = 3'd4;

    localparam logic [3:0] c_ADS_LD  = 4'(ADS_CYC - 1);
    localparam logic [3:0] c_STRB_LD = 4'(STRB_CYC - 1);

    if (ADS_CYC < 1 || ADS_CYC > 15 || STRB_CYC < 1 || STRB_CYC > 15 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("scmp_bus_ctl: parameter out of range");
    end

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [3:0]  r_flags;
    logic [7:0]  r_wdata;
    logic        r_rd;
    logic [7:0]  r_rdata;
    logic        w_accept;
    logic        w_cnt_zero;
    logic        w_strb_fin;
    logic        w_abort;

    assign w_accept   = (r_state == c_ST_IDLE) && start && (req_rd || req_wr);
    assign w_cnt_zero = (r_cnt == 4'd0);
    assign w_strb_fin = (r_state == c_ST_STRB) && w_cnt_zero && nhold_n;

`ifdef SCMP_BUS_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LIM = 8'(TIMEOUT);

    logic [7:0] r_tmo;
    logic       r_bus_err;

    assign w_abort = (r_state == c_ST_STRB) && w_cnt_zero && !nhold_n && (r_tmo == c_TMO_LIM);

    // r_tmo counts only the NHOLD extension cycles of the current bus cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo     <= 8'd0;
            r_bus_err <= 1'b0;
        end else if (w_accept) begin
            r_tmo     <= 8'd0;
            r_bus_err <= 1'b0;
        end else if (w_abort) begin
            r_bus_err <= 1'b1;
        end else if ((r_state == c_ST_STRB) && w_cnt_zero && !nhold_n) begin
            r_tmo <= r_tmo + 8'd1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_abort = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        breq_o      = 1'b0;
        enout       = 1'b0;
        ads_n       = 1'b1;
        rds_n       = 1'b1;
        wds_n       = 1'b1;
        addr_oe     = 1'b0;
        dout_oe     = 1'b0;
        flags_o     = 4'd0;
        case (r_state)
            c_ST_IDLE: begin
                enout = enin;
                if (w_accept) w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                busy   = 1'b1;
                breq_o = 1'b1;
                if (enin) w_state_nxt = c_ST_ADDR;
            end
            c_ST_ADDR: begin
                busy    = 1'b1;
                breq_o  = 1'b1;
                addr_oe = 1'b1;
                ads_n   = 1'b0;
                flags_o = r_flags;
                if (w_cnt_zero) w_state_nxt = c_ST_STRB;
            end
            c_ST_STRB: begin
                busy    = 1'b1;
                breq_o  = 1'b1;
                addr_oe = 1'b1;
                rds_n   = !r_rd;
                wds_n   = r_rd;
                dout_oe = !r_rd;
                if (w_strb_fin || w_abort) w_state_nxt = c_ST_REL;
            end
            c_ST_REL: begin
                // strobes are released but address/data keep driving for hold time
                busy        = 1'b1;
                breq_o      = 1'b1;
                addr_oe     = 1'b1;
                dout_oe     = !r_rd;
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_addr  <= 16'd0;
            r_flags <= 4'd0;
            r_wdata <= 8'd0;
            r_rd    <= 1'b0;
            r_rdata <= 8'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_flags <= req_flags;
                r_wdata <= req_wdata;
                r_rd    <= req_rd;
            end
            case (r_state)
                c_ST_REQ:  r_cnt <= c_ADS_LD;
                c_ST_ADDR: r_cnt <= w_cnt_zero ? c_STRB_LD : r_cnt - 4'd1;
                c_ST_STRB: if (!w_cnt_zero) r_cnt <= r_cnt - 4'd1;
                default:   ;
            endcase
            if (w_strb_fin && r_rd) r_rdata <= din;
        end
    end

    assign addr_o = r_addr;
    assign dout   = r_wdata;
    assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_scmp_bus_ctl                                            |
// | Description : Randomised scoreboard bench for scmp_bus_ctl; covers the   |
// |               SCMP_BUS_TIMEOUT_EN watchdog when that macro is defined.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_scmp_bus_ctl;

    localparam int c_ADS  = 2;
    localparam int c_STRB = 3;
`ifdef SCMP_BUS_TIMEOUT_EN
    localparam int c_TMO = 16;
`else
    localparam int c_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [3:0]  req_flags = 4'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        enin = 1'b1;
    logic        nhold_n = 1'b1;
    logic [7:0]  din = 8'd0;
    logic        busy, done, bus_err, breq_o, enout, ads_n, rds_n, wds_n, addr_oe, dout_oe;
    logic [7:0]  rdata, dout;
    logic [15:0] addr_o;
    logic [3:0]  flags_o;

    scmp_bus_ctl #(.ADS_CYC(c_ADS), .STRB_CYC(c_STRB), .TIMEOUT(c_TMO)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_flags(req_flags), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .bus_err(bus_err), .breq_o(breq_o),
        .enin(enin), .enout(enout), .nhold_n(nhold_n), .ads_n(ads_n), .rds_n(rds_n),
        .wds_n(wds_n), .addr_o(addr_o), .flags_o(flags_o), .addr_oe(addr_oe),
        .dout(dout), .dout_oe(dout_oe), .din(din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        logic [15:0] addr;
        logic [3:0]  flags;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          rd;
        bit          err;
        int          strb_len;
        int          breq_len;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  model_rdata = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    endtask

    // One bus cycle: w = REQ cycles spent with enin low, h = NHOLD extension cycles.
    // Caller is #1 after a posedge with the DUT idle.
    task automatic run_txn(input bit rd, input bit wr, input int w, input int h, input bit abort,
                           input logic [15:0] a, input logic [3:0] f,
                           input logic [7:0] wd, input logic [7:0] dv);
        exp_t e;
        int   d;
        int   hh;
        d  = w + c_ADS + c_STRB;
        hh = abort ? c_TMO : h;
        if (rd && !abort) model_rdata = dv;
        e.addr     = a;
        e.flags    = f;
        e.wdata    = wd;
        e.rd       = rd;
        e.rdata    = model_rdata;
        e.err      = abort;
        e.strb_len = c_STRB + hh;
        e.breq_len = d + hh + 2;
        e.done_cyc = cyc + 1 + d + hh + 1;
        sb.push_back(e);
        start = 1'b1; req_rd = rd; req_wr = wr; req_addr = a; req_flags = f; req_wdata = wd;
        enin = (w == 0);
        @(posedge clk); #1;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("bus_err_clear_on_start", {31'd0, bus_err}, 32'd0);
        for (int k = 0; k <= d + hh + 1; k++) begin
            start     = ($urandom_range(0, 3) == 0);
            req_rd    = 1'($urandom);
            req_wr    = 1'($urandom);
            req_addr  = 16'($urandom);
            req_flags = 4'($urandom);
            req_wdata = 8'($urandom);
            enin      = (k < w) ? 1'b0 : (k == w) ? 1'b1 : 1'($urandom);
            if (k >= d && (k < d + hh || abort)) nhold_n = 1'b0;
            else if (k < d)                      nhold_n = 1'($urandom);
            else                                 nhold_n = 1'b1;
            din = (k == d + hh) ? dv : 8'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; req_rd = 1'b0; req_wr = 1'b0; enin = 1'b1; nhold_n = 1'b1;
    endtask

    // Monitor: per-cycle strobe accounting, compared against the queue head on done
    int   n_ads = 0, n_rds = 0, n_wds = 0, n_doe = 0, n_aoe = 0, n_breq = 0;
    int   bad_addr = 0, bad_dout = 0, viol_en = 0;
    bit   post_done = 1'b0;
    exp_t m;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_ads = 0; n_rds = 0; n_wds = 0; n_doe = 0; n_aoe = 0; n_breq = 0;
                bad_addr = 0; bad_dout = 0; post_done = 1'b0;
            end else begin
                if (post_done) begin
                    chk("busy_after_done", {31'd0, busy}, 32'd0);
                    chk("breq_after_done", {31'd0, breq_o}, 32'd0);
                    chk("done_single_pulse", {31'd0, done}, 32'd0);
                    post_done = 1'b0;
                end
                if (breq_o)  n_breq++;
                if (addr_oe) n_aoe++;
                if (dout_oe) n_doe++;
                if (!rds_n)  n_rds++;
                if (!ads_n) begin
                    n_ads++;
                    if (sb.size() > 0 && (addr_o !== sb[0].addr || flags_o !== sb[0].flags)) bad_addr++;
                end
                if (!wds_n) begin
                    n_wds++;
                    if (sb.size() > 0 && dout !== sb[0].wdata) bad_dout++;
                end
                if (busy ? (enout !== 1'b0) : (enout !== enin)) viol_en++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        m = sb.pop_front();
                        chk("done_cycle", cyc, m.done_cyc);
                        chk("rdata", {24'd0, rdata}, {24'd0, m.rdata});
                        chk("bus_err", {31'd0, bus_err}, {31'd0, m.err});
                        chk("ads_len", n_ads, c_ADS);
                        chk("rds_len", n_rds, m.rd ? m.strb_len : 0);
                        chk("wds_len", n_wds, m.rd ? 0 : m.strb_len);
                        chk("dout_oe_len", n_doe, m.rd ? 0 : m.strb_len + 1);
                        chk("addr_oe_len", n_aoe, c_ADS + m.strb_len + 1);
                        chk("breq_len", n_breq, m.breq_len);
                        chk("addr_flags_bus", bad_addr, 0);
                        chk("dout_bus", bad_dout, 0);
                    end
                    n_ads = 0; n_rds = 0; n_wds = 0; n_doe = 0; n_aoe = 0; n_breq = 0;
                    bad_addr = 0; bad_dout = 0; post_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_breq"}, {31'd0, breq_o}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, ads_n, rds_n, wds_n}, 32'd7);
        chk({tag, "_oe"}, {30'd0, addr_oe, dout_oe}, 32'd0);
        chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        chk({tag, "_addr_o"}, {16'd0, addr_o}, 32'd0);
        chk({tag, "_flags_dout"}, {20'd0, flags_o, dout}, 32'd0);
        chk({tag, "_enout"}, {31'd0, enout}, {31'd0, enin});
    endtask

    initial begin
        bit rd, wr;
        #3;
        chk_reset_outputs("por");
        enin = 1'b0; #1;
        chk("por_enout_follows_enin", {31'd0, enout}, 32'd0);
        enin = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b0, 0,  0, 1'b0, 16'h1234, 4'h5, 8'h00, 8'hA5);
        run_txn(1'b0, 1'b1, 0,  0, 1'b0, 16'h0FFF, 4'hA, 8'h3C, 8'h77);
        run_txn(1'b1, 1'b0, 10, 0, 1'b0, 16'h2001, 4'h3, 8'h11, 8'h5A);
        run_txn(1'b1, 1'b0, 0,  4, 1'b0, 16'hC0DE, 4'hF, 8'h22, 8'hE7);
        run_txn(1'b1, 1'b1, 1,  1, 1'b0, 16'h8000, 4'h1, 8'h99, 8'h3D);

        start = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("no_dir_start_ignored", {31'd0, busy}, 32'd0);

        // reset in the middle of STRB
        start = 1'b1; req_rd = 1'b1; req_addr = 16'hBEEF; req_flags = 4'h6;
        @(posedge clk); #1;
        start = 1'b0; req_rd = 1'b0;
        repeat (c_ADS + 2) @(posedge clk);
        #1;
        chk("pre_reset_in_strb", {31'd0, rds_n}, 32'd0);
        rst_n = 1'b0; #1;
        chk_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_rdata = 8'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_idle", {31'd0, busy}, 32'd0);
        run_txn(1'b1, 1'b0, 0, 0, 1'b0, 16'h4321, 4'h9, 8'h00, 8'h6C);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            run_txn(rd, wr, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                    16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
                @(posedge clk); #1;
                start = 1'b0;
                chk("no_dir_start_ignored", {31'd0, busy}, 32'd0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

`ifdef SCMP_BUS_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 0, 0, 1'b1, 16'h0A0A, 4'h2, 8'h00, ~model_rdata);
        run_txn(1'b1, 1'b0, 0, 2, 1'b0, 16'h0B0B, 4'h4, 8'h00, 8'hC3);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("enout_rule", viol_en, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
